// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - multicycle ALU execution unit with start/done handshake
module alu_seq_unit #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1,
  parameter int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [2:0]       func3,
  input  logic             funct_mod,
  input  logic [1:0]       Branch_funct,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             BranchTaken,
  output logic             illegal
);

  // Counter must hold WIDTH itself for the multiply iteration count.
  localparam int CW = SHW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC1,
    S_SHIFT,
    S_MUL,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLT,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_MUL,
    OP_ILL
  } op_t;

  state_t           state_q, state_d;
  op_t              dec_op, op_q;
  logic             dec_br, is_br_q;
  logic [1:0]       br_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] exec_res, shift_step;
  logic             lt, eq, br_taken;
  logic             dec_is_shift;

  // Decode the incoming instruction fields into an internal operation.
  always_comb begin
    dec_op = OP_ILL;
    dec_br = 1'b0;
    case (ALUOp)
      2'b00, 2'b11: dec_op = OP_ADD;
      2'b01: begin
        dec_br = 1'b1;
        dec_op = Branch_funct[1] ? OP_SLT : OP_SUB;
      end
      default: begin
        case (func3)
          3'b000:  dec_op = funct_mod ? (MUL_EN ? OP_MUL : OP_ILL) : OP_ADD;
          3'b001:  dec_op = funct_mod ? OP_ILL : OP_SUB;
          3'b111:  dec_op = funct_mod ? OP_ILL : OP_AND;
          3'b110:  dec_op = funct_mod ? OP_ILL : OP_OR;
          3'b100:  dec_op = OP_XOR;
          3'b010:  dec_op = funct_mod ? OP_ILL : OP_SLT;
          3'b011:  dec_op = OP_SLL;
          default: dec_op = funct_mod ? OP_SRA : OP_SRL;
        endcase
      end
    endcase
  end

  assign dec_is_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);

  // Single-cycle results and branch condition from the latched operands.
  always_comb begin
    lt       = $signed(a_q) < $signed(b_q);
    eq       = (a_q == b_q);
    exec_res = '0;
    case (op_q)
      OP_ADD:  exec_res = a_q + b_q;
      OP_SUB:  exec_res = a_q - b_q;
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_SLT:  exec_res = {{(WIDTH-1){1'b0}}, lt};
      default: exec_res = '0;
    endcase
    case (br_q)
      2'b00:   br_taken = eq;
      2'b01:   br_taken = !eq;
      2'b10:   br_taken = lt;
      default: br_taken = !lt;
    endcase
  end

  // One-bit shift of the working register in the latched direction.
  always_comb begin
    shift_step = a_q;
    case (op_q)
      OP_SLL:  shift_step = {a_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, a_q[WIDTH-1:1]};
      OP_SRA:  shift_step = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      default: shift_step = a_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dec_is_shift)          state_d = S_SHIFT;
          else if (dec_op == OP_MUL) state_d = S_MUL;
          else                       state_d = S_EXEC1;
        end
      end
      S_EXEC1: state_d = S_DONE;
      S_SHIFT: if (cnt_q == '0) state_d = S_DONE;
      S_MUL:   if (cnt_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch, iterative shift/multiply datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= OP_ADD;
      is_br_q     <= 1'b0;
      br_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ALUResult   <= '0;
      BranchTaken <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= dec_op;
            is_br_q <= dec_br;
            br_q    <= Branch_funct;
            a_q     <= SrcA;
            b_q     <= SrcB;
            acc_q   <= '0;
            if (dec_op == OP_MUL) cnt_q <= CW'(WIDTH);
            else if (dec_is_shift) cnt_q <= {1'b0, SrcB[SHW-1:0]};
            else cnt_q <= '0;
          end
        end
        S_EXEC1: begin
          ALUResult   <= exec_res;
          BranchTaken <= is_br_q & br_taken;
          illegal     <= (op_q == OP_ILL);
        end
        S_SHIFT: begin
          if (cnt_q == '0) begin
            ALUResult   <= a_q;
            BranchTaken <= 1'b0;
            illegal     <= 1'b0;
          end else begin
            a_q   <= shift_step;
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            ALUResult   <= acc_q;
            BranchTaken <= 1'b0;
            illegal     <= 1'b0;
          end else begin
            acc_q <= acc_q + (b_q[0] ? a_q : '0);
            a_q   <= {a_q[WIDTH-2:0], 1'b0};
            b_q   <= {1'b0, b_q[WIDTH-1:1]};
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == S_EXEC1) || (state_q == S_SHIFT) || (state_q == S_MUL);
  assign done = (state_q == S_DONE);
  assign Zero = (ALUResult == '0);

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - self-checking bench for alu_seq_unit
module tb_alu_seq_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start0, start1;
  logic [1:0]   ALUOp;
  logic [2:0]   func3;
  logic         funct_mod;
  logic [1:0]   Branch_funct;
  logic [W-1:0] SrcA, SrcB;
  logic         busy0, done0, zero0, bt0, ill0;
  logic         busy1, done1, zero1, bt1, ill1;
  logic [W-1:0] res0, res1;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .ALUOp(ALUOp), .func3(func3),
    .funct_mod(funct_mod), .Branch_funct(Branch_funct), .SrcA(SrcA), .SrcB(SrcB),
    .busy(busy0), .done(done0), .ALUResult(res0), .Zero(zero0),
    .BranchTaken(bt0), .illegal(ill0)
  );

  alu_seq_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ALUOp(ALUOp), .func3(func3),
    .funct_mod(funct_mod), .Branch_funct(Branch_funct), .SrcA(SrcA), .SrcB(SrcB),
    .busy(busy1), .done(done1), .ALUResult(res1), .Zero(zero1),
    .BranchTaken(bt1), .illegal(ill1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit use0, output logic d, output logic b, output logic [W-1:0] r,
                        output logic z, output logic t, output logic il);
    d  = use0 ? done0 : done1;
    b  = use0 ? busy0 : busy1;
    r  = use0 ? res0  : res1;
    z  = use0 ? zero0 : zero1;
    t  = use0 ? bt0   : bt1;
    il = use0 ? ill0  : ill1;
  endtask

  // Reference: result, branch flag, illegal flag and latency straight from the decode table.
  function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic fm,
                                input logic [1:0] bf, input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit mul_en, output logic [W-1:0] res, output logic bt,
                                output logic ill, output int lat);
    int sh;
    logic lt;
    logic [2*W-1:0] prod;
    sh   = int'(b[3:0]);
    lt   = $signed(a) < $signed(b);
    prod = a * b;
    res = '0; bt = 1'b0; ill = 1'b0; lat = 2;
    if (op == 2'b00 || op == 2'b11) begin
      res = a + b;
    end else if (op == 2'b01) begin
      res = bf[1] ? {{(W-1){1'b0}}, lt} : a - b;
      case (bf)
        2'd0: bt = (a == b);
        2'd1: bt = (a != b);
        2'd2: bt = lt;
        default: bt = !lt;
      endcase
    end else begin
      case (f3)
        3'b000: begin
          if (!fm) res = a + b;
          else if (mul_en) begin res = prod[W-1:0]; lat = W + 2; end
          else ill = 1'b1;
        end
        3'b001: if (fm) ill = 1'b1; else res = a - b;
        3'b111: if (fm) ill = 1'b1; else res = a & b;
        3'b110: if (fm) ill = 1'b1; else res = a | b;
        3'b100: res = a ^ b;
        3'b010: if (fm) ill = 1'b1; else res = {{(W-1){1'b0}}, lt};
        3'b011: begin res = a << sh; lat = sh + 2; end
        default: begin
          res = fm ? W'($signed(a) >>> sh) : a >> sh;
          lat = sh + 2;
        end
      endcase
    end
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3, input logic fm,
                        input logic [1:0] bf, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit use0);
    logic [W-1:0] er, r;
    logic ebt, eill, d, bs, z, t, il;
    int elat, k;
    bit seen;
    model(op, f3, fm, bf, a, b, !use0, er, ebt, eill, elat);
    @(negedge clk);
    ALUOp = op; func3 = f3; funct_mod = fm; Branch_funct = bf; SrcA = a; SrcB = b;
    if (use0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    SrcA = W'($urandom); SrcB = W'($urandom); ALUOp = 2'($urandom);
    func3 = 3'($urandom); funct_mod = 1'($urandom); Branch_funct = 2'($urandom);
    k = 1; seen = 1'b0;
    while (!seen && k <= 40) begin
      sample(use0, d, bs, r, z, t, il);
      if (d) seen = 1'b1;
      else begin
        check({tag, " busy"}, bs, 1'b1);
        @(posedge clk); #1;
        k++;
      end
    end
    check({tag, " done_seen"}, seen, 1'b1);
    if (seen) begin
      sample(use0, d, bs, r, z, t, il);
      check({tag, " latency"}, 64'(k), 64'(elat));
      check({tag, " busy_at_done"}, bs, 1'b0);
      check({tag, " result"}, r, er);
      check({tag, " zero"}, z, (er == '0));
      check({tag, " branch"}, t, ebt);
      check({tag, " illegal"}, il, eill);
      @(posedge clk); #1;
      sample(use0, d, bs, r, z, t, il);
      check({tag, " done_pulse"}, d, 1'b0);
      check({tag, " hold"}, r, er);
    end
  endtask

  initial begin
    logic [W-1:0] r;
    logic d, bs, z, t, il, done_any;
    logic [1:0] op;
    logic [2:0] f3;
    logic fm;

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    ALUOp = 2'b00; func3 = 3'b000; funct_mod = 1'b0; Branch_funct = 2'b00;
    SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy1, 1'b0);
    check("rst done", done1, 1'b0);
    check("rst result", res1, 16'h0);
    check("rst zero", zero1, 1'b1);
    check("rst branch", bt1, 1'b0);
    check("rst illegal", ill1, 1'b0);
    check("rst0 result", res0, 16'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op("r_add",   2'b10, 3'b000, 1'b0, 2'b00, 16'h7FFF, 16'h0001, 1'b0);
    run_op("r_add1",  2'b10, 3'b000, 1'b0, 2'b00, 16'h7FFF, 16'h0001, 1'b1);
    run_op("r_sub",   2'b10, 3'b001, 1'b0, 2'b00, 16'h1234, 16'h1234, 1'b1);
    run_op("blt",     2'b01, 3'b000, 1'b0, 2'b10, 16'hFFFE, 16'h0003, 1'b1);
    run_op("bge",     2'b01, 3'b000, 1'b0, 2'b11, 16'hFFFE, 16'h0003, 1'b1);
    run_op("bne",     2'b01, 3'b000, 1'b0, 2'b01, 16'hFFFE, 16'h0003, 1'b1);
    run_op("beq",     2'b01, 3'b000, 1'b0, 2'b00, 16'h5A5A, 16'h5A5A, 1'b1);
    run_op("sll4",    2'b10, 3'b011, 1'b0, 2'b00, 16'h8001, 16'h0004, 1'b1);
    run_op("srl15",   2'b10, 3'b101, 1'b0, 2'b00, 16'h8001, 16'h000F, 1'b1);
    run_op("sra15",   2'b10, 3'b101, 1'b1, 2'b00, 16'h8001, 16'h000F, 1'b1);
    run_op("sll0",    2'b10, 3'b011, 1'b0, 2'b00, 16'h8001, 16'h0020, 1'b1);
    run_op("mul",     2'b10, 3'b000, 1'b1, 2'b00, 16'h0123, 16'h0045, 1'b1);
    run_op("mul_ff",  2'b10, 3'b000, 1'b1, 2'b00, 16'hFFFF, 16'hFFFF, 1'b1);
    run_op("mul_dis", 2'b10, 3'b000, 1'b1, 2'b00, 16'h0123, 16'h0045, 1'b0);
    run_op("s_add",   2'b00, 3'b111, 1'b1, 2'b00, 16'hFFFF, 16'h0002, 1'b1);

    // start held high: one op per three cycles, nothing accepted in the done cycle
    @(negedge clk);
    ALUOp = 2'b11; func3 = 3'b000; funct_mod = 1'b0; SrcA = 16'd5; SrcB = 16'd6;
    start1 = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      check("hold_start busy", busy1, (j % 3 == 0));
      check("hold_start done", done1, (j % 3 == 1));
    end
    start1 = 1'b0;
    check("hold_start result", res1, 16'd11);

    // reset in the middle of a multiply
    @(negedge clk);
    ALUOp = 2'b10; func3 = 3'b000; funct_mod = 1'b1; SrcA = 16'h0123; SrcB = 16'h0045;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_mul busy", busy1, 1'b1);
    reset = 1'b1;
    #1;
    check("abort busy", busy1, 1'b0);
    check("abort done", done1, 1'b0);
    check("abort result", res1, 16'h0);
    check("abort zero", zero1, 1'b1);
    check("abort illegal", ill1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    done_any = 1'b0;
    for (int j = 0; j < 25; j++) begin
      @(posedge clk); #1;
      if (done1) done_any = 1'b1;
    end
    check("abort no_done", done_any, 1'b0);
    run_op("add_after_rst", 2'b11, 3'b010, 1'b0, 2'b00, 16'h1000, 16'h0234, 1'b1);

    // randomized operations against the reference model
    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom);
      f3 = 3'($urandom);
      fm = 1'($urandom);
      if (op == 2'b10 && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111)) fm = 1'b0;
      run_op($sformatf("rnd%0d", i), op, f3, fm, 2'($urandom), W'($urandom), W'($urandom),
             (i % 8 == 7));
    end
    sample(1'b1, d, bs, r, z, t, il);
    check("final idle", bs, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised multicycle ALU execution unit for the multicycle RISC-V core: it replaces the combinational ALU control decode with a block that decodes ALUOp/func3/Branch_funct, latches operands on a start handshake, and computes the result. Single-cycle ops finish in one cycle. Shifts run iteratively at one bit per cycle, and the optional multiply is shift-add. It sits between the register-operand muxes and the ALUOut register and is sequenced by the main control FSM through start/done.

## Interface
- WIDTH, 16, datapath width in bits; must be a power of two, 8 or more.
- MUL_EN, 1, 1 enables the iterative MUL; 0 makes MUL encodings illegal.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only in IDLE.
- ALUOp  in  2  00 S-type, 01 B-type, 10 R-type, 11 I-type.
- func3  in  3  instruction func3.
- funct_mod  in  1  instruction bit 30 (R-type modifier).
- Branch_funct  in  2  00 beq, 01 bne, 10 blt, 11 bge.
- SrcA, SrcB  in  WIDTH  operands.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse; the outputs below are valid from this cycle.
- ALUResult  out  WIDTH  result; held until the next accepted start.
- Zero  out  1  ALUResult == 0.
- BranchTaken  out  1  branch condition result (B-type only, else 0).
- illegal  out  1  unsupported encoding; held with the result.

## Operation
- Decode when ALUOp is 00 (S-type) or 11 (I-type): ADD.
- Decode when ALUOp is 01 (B-type):
  - beq and bne: SUB.
  - blt and bge: SLT.
  - BranchTaken: beq A==B, bne A!=B, blt signed A<B, bge signed A>=B.
- Decode when ALUOp is 10 (R-type), by func3:
  - 000: ADD, or MUL when funct_mod=1.
  - 001: SUB.
  - 111: AND.
  - 110: OR.
  - 100: XOR.
  - 010: SLT (signed).
  - 011: SLL.
  - 101: SRL, or SRA when funct_mod=1.
- Illegal encodings:
  - R-type func3 011/100/101 keep their ops regardless of funct_mod, except 101, which selects SRA.
  - MUL with MUL_EN=0 is illegal.
  - Any other unlisted code is illegal.
  - Illegal ops complete in 1 cycle with ALUResult=0, Zero=1, BranchTaken=0, illegal=1. An undriven result is never produced.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT returns 1 or 0, zero-extended.
  - MUL returns the low WIDTH bits of the product. Signed and unsigned low halves are identical.
- Shifts:
  - shamt = SrcB[SHW-1:0]; upper bits are ignored.
  - SRA replicates the sign bit.
- FSM states and transitions:
  - IDLE: start=1 → latch SrcA, SrcB and the decoded op. Go to EXEC1 for single-cycle or illegal ops, SHIFT for shifts, MUL for multiply.
  - EXEC1 → DONE.
  - SHIFT: shift the working register one bit and decrement the counter each cycle. When the counter reaches 0 → DONE. shamt=0 goes straight to DONE.
  - MUL: examine one multiplier bit per cycle, conditionally add the shifted multiplicand. After WIDTH cycles → DONE.
  - DONE: assert done; return to IDLE.
- Handshake:
  - start is ignored while not in IDLE (busy=1 or done=1).
  - A start that coincides with the done cycle is ignored. The requester must re-assert start in a later IDLE cycle.
  - Input changes after acceptance do not affect the operation in flight.

## Timing
- Acceptance edge = cycle 0.
- Latency from start to the done pulse:
  - single-cycle or illegal ops: cycle 2.
  - shifts: cycle shamt+2.
  - MUL: cycle WIDTH+2.
- busy is high from cycle 1 through the cycle before done. done is never high together with busy.
- Back-to-back: the next start is accepted at the earliest in the cycle after done, so a single-cycle op has a throughput of one op per 3 cycles.
- Reset values: state IDLE, busy=0, done=0, ALUResult=0, Zero=1, BranchTaken=0, illegal=0, internal counters 0.
- Reset asserted mid-operation aborts immediately; no done is issued for the aborted op.
- Zero, BranchTaken and illegal update only at done and hold alongside ALUResult.

## Test plan
- R ADD: A=0x7FFF, B=0x0001, WIDTH=16 → done at cycle 2, ALUResult=0x8000, Zero=0. Then SUB with A=B=0x1234 → ALUResult=0, Zero=1.
- Branch: A=0xFFFE (−2), B=0x0003.
  - blt → BranchTaken=1.
  - bge → BranchTaken=0.
  - bne → BranchTaken=1.
  - beq with A=B → BranchTaken=1, Zero=1.
- Shifts: A=0x8001.
  - SLL shamt 4 → 0x0010, done at cycle 6.
  - SRL shamt 15 → 0x0001.
  - SRA shamt 15 → 0xFFFF.
  - B=0x0020 (shamt 0) → unchanged, done at cycle 2.
- MUL: A=0x0123, B=0x0045 → 0x4E6F, done at cycle 18.
  - A=0xFFFF, B=0xFFFF → 0x0001.
  - With MUL_EN=0 → illegal=1, ALUResult=0.
- Handshake and illegal:
  - start held high continuously → exactly one accepted op per done, none accepted in the done cycle.
  - R func3 000, funct_mod=1 with MUL_EN=0 → illegal=1.
- Reset: assert reset at cycle 5 of a MUL → outputs return to reset values, no done pulse. A new ADD after reset completes normally.
